// File: rtl/mips_bus_arbiter.sv
// Shares one Avalon-style bus between the fetch port and the load/store port.
// Define ARB_ROUND_ROBIN_EN to alternate grants when both ports contend.
module mips_bus_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                i_req,
   input  logic [ADDR_W-1:0]   i_addr,
   output logic                i_ack,
   output logic [DATA_W-1:0]   i_rdata,
   input  logic                d_req,
   input  logic                d_we,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   input  logic [DATA_W/8-1:0] d_be,
   output logic                d_ack,
   output logic [DATA_W-1:0]   d_rdata,
   output logic [1:0]          grant,
   output logic [ADDR_W-1:0]   address,
   output logic                write,
   output logic                read,
   input  logic                waitrequest,
   output logic [DATA_W-1:0]   writedata,
   output logic [DATA_W/8-1:0] byteenable,
   input  logic [DATA_W-1:0]   readdata
);
   localparam int BE_W = DATA_W / 8;

   typedef enum logic [1:0] {IDLE, BUS_I, BUS_D} state_t;

   state_t            state, state_n;
   logic [1:0]        grant_n;
   logic              read_n, write_n, i_ack_n, d_ack_n;
   logic [ADDR_W-1:0] address_n;
   logic [DATA_W-1:0] writedata_n, i_rdata_n, d_rdata_n;
   logic [BE_W-1:0]   byteenable_n;
   logic              i_elig, d_elig, pick_d;

   // A port is not eligible during its own ack cycle, so a held req is not replayed.
   assign i_elig = i_req && !i_ack;
   assign d_elig = d_req && !d_ack;

`ifdef ARB_ROUND_ROBIN_EN
   logic last_d, last_d_n;

   assign pick_d   = d_elig && (!i_elig || !last_d);
   assign last_d_n = (state == IDLE && (d_elig || i_elig)) ? pick_d : last_d;

   always_ff @(posedge clk) begin
      if (reset) last_d <= 1'b0;
      else       last_d <= last_d_n;
   end
`else
   assign pick_d = d_elig;
`endif

   always_comb begin
      state_n      = state;
      grant_n      = grant;
      read_n       = read;
      write_n      = write;
      address_n    = address;
      writedata_n  = writedata;
      byteenable_n = byteenable;
      i_ack_n      = 1'b0;
      d_ack_n      = 1'b0;
      i_rdata_n    = i_rdata;
      d_rdata_n    = d_rdata;
      unique case (state)
         IDLE: begin
            if (pick_d) begin
               state_n      = BUS_D;
               grant_n      = 2'b10;
               address_n    = d_addr;
               writedata_n  = d_wdata;
               byteenable_n = d_be;
               write_n      = d_we;
               read_n       = !d_we;
            end else if (i_elig) begin
               state_n      = BUS_I;
               grant_n      = 2'b01;
               address_n    = i_addr;
               writedata_n  = '0;
               byteenable_n = '1;
               write_n      = 1'b0;
               read_n       = 1'b1;
            end
         end
         BUS_I, BUS_D: begin
            if (!waitrequest) begin
               state_n = IDLE;
               grant_n = 2'b00;
               read_n  = 1'b0;
               write_n = 1'b0;
               if (state == BUS_I) begin
                  i_ack_n   = 1'b1;
                  i_rdata_n = readdata;
               end else begin
                  d_ack_n = 1'b1;
                  if (read) d_rdata_n = readdata;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         grant      <= 2'b00;
         read       <= 1'b0;
         write      <= 1'b0;
         address    <= '0;
         writedata  <= '0;
         byteenable <= '0;
         i_ack      <= 1'b0;
         d_ack      <= 1'b0;
         i_rdata    <= '0;
         d_rdata    <= '0;
      end else begin
         state      <= state_n;
         grant      <= grant_n;
         read       <= read_n;
         write      <= write_n;
         address    <= address_n;
         writedata  <= writedata_n;
         byteenable <= byteenable_n;
         i_ack      <= i_ack_n;
         d_ack      <= d_ack_n;
         i_rdata    <= i_rdata_n;
         d_rdata    <= d_rdata_n;
      end
   end
endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Bench for mips_bus_arbiter: directed vector table, then random traffic
// checked against a transaction-level model with a small word memory.
module tb_mips_bus_arbiter;
   logic        clk = 1'b0;
   logic        reset;
   logic        i_req, i_ack, d_req, d_we, d_ack;
   logic        write, read, waitrequest;
   logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata;
   logic [31:0] address, writedata, readdata;
   logic [3:0]  d_be, byteenable;
   logic [1:0]  grant;

   int ncmp = 0;
   int nerr = 0;

   mips_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_be(d_be), .d_ack(d_ack), .d_rdata(d_rdata),
      .grant(grant), .address(address), .write(write), .read(read),
      .waitrequest(waitrequest), .writedata(writedata),
      .byteenable(byteenable), .readdata(readdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst, ireq;
      logic [31:0] iaddr;
      logic        dreq, dwe;
      logic [31:0] daddr, dwdata;
      logic [3:0]  dbe;
      logic        wt;
      logic [31:0] rdata;
      logic [1:0]  g;
      logic        rd, wr;
      logic [31:0] a, wd;
      logic [3:0]  be;
      logic        ia, da;
      logic [31:0] ird, drd;
   } vec_t;

   function automatic vec_t mk(
      input logic rst, input logic ireq, input logic [31:0] iaddr,
      input logic dreq, input logic dwe, input logic [31:0] daddr,
      input logic [31:0] dwdata, input logic [3:0] dbe, input logic wt,
      input logic [31:0] rdata, input logic [1:0] g, input logic rd,
      input logic wr, input logic [31:0] a, input logic [31:0] wd,
      input logic [3:0] be, input logic ia, input logic da,
      input logic [31:0] ird, input logic [31:0] drd);
      vec_t v;
      v.rst = rst; v.ireq = ireq; v.iaddr = iaddr; v.dreq = dreq;
      v.dwe = dwe; v.daddr = daddr; v.dwdata = dwdata; v.dbe = dbe;
      v.wt = wt; v.rdata = rdata; v.g = g; v.rd = rd; v.wr = wr;
      v.a = a; v.wd = wd; v.be = be; v.ia = ia; v.da = da;
      v.ird = ird; v.drd = drd;
      return v;
   endfunction

   function automatic logic [137:0] outs();
      return {grant, read, write, address, writedata, byteenable,
              i_ack, d_ack, i_rdata, d_rdata};
   endfunction

   task automatic check(input string name, input logic [137:0] exp);
      ncmp++;
      if (outs() !== exp) begin
         nerr++;
         $display("FAIL %s got %h expected %h", name, outs(), exp);
      end
   endtask

   vec_t vt[$];

   logic [31:0] mem [16];
   int          ow;
   logic        cwe, lastd, ie, de, pd;
   logic [31:0] ca, cwd;
   logic [3:0]  cbe;
   logic [1:0]  eg;
   logic        erd, ewr, eia, eda;
   logic [31:0] ea, ewd, eir, edr;
   logic [3:0]  ebe;

   initial begin
      // rst ireq iaddr dreq dwe daddr dwdata dbe wt rdata | g rd wr a wd be ia da ird drd
      vt.push_back(mk(1,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0));
      vt.push_back(mk(0,1,32'hBFC00000,0,0,0,0,0,0,0, 1,1,0,32'hBFC00000,0,4'hF,0,0,0,0));
      vt.push_back(mk(0,1,32'hBFC00000,0,0,0,0,0,0,32'h8C020010, 0,0,0,32'hBFC00000,0,4'hF,1,0,32'h8C020010,0));
      vt.push_back(mk(0,1,32'hBFC00000,0,0,0,0,0,0,0, 0,0,0,32'hBFC00000,0,4'hF,0,0,32'h8C020010,0));
      vt.push_back(mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,32'hBFC00000,0,4'hF,0,0,32'h8C020010,0));
      vt.push_back(mk(0,0,0,1,0,32'h10,0,4'hF,0,0, 2,1,0,32'h10,0,4'hF,0,0,32'h8C020010,0));
      for (int k = 0; k < 3; k++)
         vt.push_back(mk(0,0,0,1,0,32'h10,0,4'hF,1,32'hDEAD0000, 2,1,0,32'h10,0,4'hF,0,0,32'h8C020010,0));
      vt.push_back(mk(0,0,0,1,0,32'h10,0,4'hF,0,32'hCAFE2105, 0,0,0,32'h10,0,4'hF,0,1,32'h8C020010,32'hCAFE2105));
      vt.push_back(mk(0,0,0,1,0,32'h10,0,4'hF,0,0, 0,0,0,32'h10,0,4'hF,0,0,32'h8C020010,32'hCAFE2105));
      vt.push_back(mk(0,0,0,1,1,32'h20,32'h12345678,4'h3,0,0, 2,0,1,32'h20,32'h12345678,4'h3,0,0,32'h8C020010,32'hCAFE2105));
      vt.push_back(mk(0,0,0,1,1,32'h20,32'h12345678,4'h3,0,32'h55555555, 0,0,0,32'h20,32'h12345678,4'h3,0,1,32'h8C020010,32'hCAFE2105));
      vt.push_back(mk(0,1,32'h20,0,0,0,0,0,0,0, 1,1,0,32'h20,0,4'hF,0,0,32'h8C020010,32'hCAFE2105));
      vt.push_back(mk(0,1,32'h20,0,0,0,0,0,0,32'h00005678, 0,0,0,32'h20,0,4'hF,1,0,32'h00005678,32'hCAFE2105));
      vt.push_back(mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,32'h20,0,4'hF,0,0,32'h00005678,32'hCAFE2105));
      vt.push_back(mk(0,1,32'h100,1,0,32'h200,0,4'hF,0,0, 2,1,0,32'h200,0,4'hF,0,0,32'h00005678,32'hCAFE2105));
      vt.push_back(mk(0,1,32'h100,1,0,32'h200,0,4'hF,0,32'h11111111, 0,0,0,32'h200,0,4'hF,0,1,32'h00005678,32'h11111111));
      vt.push_back(mk(0,1,32'h100,1,0,32'h200,0,4'hF,0,0, 1,1,0,32'h100,0,4'hF,0,0,32'h00005678,32'h11111111));
      vt.push_back(mk(0,1,32'h100,0,0,0,0,0,0,32'h22222222, 0,0,0,32'h100,0,4'hF,1,0,32'h22222222,32'h11111111));
      vt.push_back(mk(0,0,0,1,0,32'h40,0,4'hF,0,0, 2,1,0,32'h40,0,4'hF,0,0,32'h22222222,32'h11111111));
      vt.push_back(mk(0,0,0,1,0,32'h40,0,4'hF,1,0, 2,1,0,32'h40,0,4'hF,0,0,32'h22222222,32'h11111111));
      vt.push_back(mk(1,0,0,1,0,32'h40,0,4'hF,1,0, 0,0,0,0,0,0,0,0,0,0));
      vt.push_back(mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0));
      vt.push_back(mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0));

      for (int k = 0; k < vt.size(); k++) begin
         reset = vt[k].rst; i_req = vt[k].ireq; i_addr = vt[k].iaddr;
         d_req = vt[k].dreq; d_we = vt[k].dwe; d_addr = vt[k].daddr;
         d_wdata = vt[k].dwdata; d_be = vt[k].dbe;
         waitrequest = vt[k].wt; readdata = vt[k].rdata;
         @(negedge clk);
         check($sformatf("vec%0d", k),
               {vt[k].g, vt[k].rd, vt[k].wr, vt[k].a, vt[k].wd, vt[k].be,
                vt[k].ia, vt[k].da, vt[k].ird, vt[k].drd});
      end

      for (int i = 0; i < 16; i++) mem[i] = $urandom;
      ow = 0; lastd = 1'b0; cwe = 1'b0; ca = '0; cwd = '0; cbe = '0;
      eg = '0; erd = 0; ewr = 0; eia = 0; eda = 0;
      ea = '0; ewd = '0; ebe = '0; eir = '0; edr = '0;

      for (int cyc = 0; cyc < 500; cyc++) begin
         if (eia || !i_req) begin
            i_req  = 1'($urandom_range(1, 0));
            i_addr = {26'h0, 4'($urandom_range(15, 0)), 2'b00};
         end
         if (eda || !d_req) begin
            d_req   = 1'($urandom_range(1, 0));
            d_we    = 1'($urandom_range(1, 0));
            d_addr  = {26'h0, 4'($urandom_range(15, 0)), 2'b00};
            d_wdata = $urandom;
            d_be    = 4'($urandom_range(15, 1));
         end
         waitrequest = ($urandom_range(2, 0) == 0);
         readdata = (ow != 0 && !cwe) ? mem[ca[5:2]] : $urandom;

         if (ow != 0) begin
            if (!waitrequest) begin
               if (cwe) begin
                  for (int b = 0; b < 4; b++)
                     if (cbe[b]) mem[ca[5:2]][8*b +: 8] = cwd[8*b +: 8];
               end else if (ow == 1) eir = mem[ca[5:2]];
               else edr = mem[ca[5:2]];
               eia = (ow == 1); eda = (ow == 2);
               eg = 2'b00; erd = 0; ewr = 0; ow = 0;
            end else begin
               eia = 0; eda = 0;
            end
         end else begin
            ie = i_req && !eia;
            de = d_req && !eda;
            eia = 0; eda = 0;
`ifdef ARB_ROUND_ROBIN_EN
            pd = de && (!ie || !lastd);
`else
            pd = de;
`endif
            if (pd) begin
               ow = 2; cwe = d_we; ca = d_addr; cwd = d_wdata; cbe = d_be;
               lastd = 1'b1;
            end else if (ie) begin
               ow = 1; cwe = 0; ca = i_addr; cwd = '0; cbe = 4'hF;
               lastd = 1'b0;
            end
            if (ow != 0) begin
               eg = (ow == 1) ? 2'b01 : 2'b10;
               erd = !cwe; ewr = cwe; ea = ca; ewd = cwd; ebe = cbe;
            end
         end

         @(negedge clk);
         check($sformatf("rand%0d", cyc),
               {eg, erd, ewr, ea, ewd, ebe, eia, eda, eir, edr});
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end
endmodule

// File: doc/mips_bus_arbiter.md
Name: mips_bus_arbiter

Overview:
- Shares the single Avalon-style memory bus (address, write, read, waitrequest, writedata, byteenable, readdata) between the CPU's instruction-fetch port and its load/store data port.
- Sits inside mips_cpu_bus, between the fetch/LSU logic and the external bus that drives RAM_32x4096.
- Owns one outstanding transaction at a time, holds it through waitrequest stalls, and returns read data with a one-cycle ack pulse.

Parameters:
ADDR_W, 32, bus and requester address width
DATA_W, 32, bus data width; byteenable width is DATA_W/8

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
i_req  in  1  fetch request; held with i_addr until i_ack
i_addr  in  ADDR_W  fetch address
i_ack  out  1  one-cycle pulse when the fetch completes
i_rdata  out  DATA_W  fetched word; valid while i_ack=1, held until next fetch ack
d_req  in  1  data request; held with d_we/d_addr/d_wdata/d_be until d_ack
d_we  in  1  1=store, 0=load
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_be  in  DATA_W/8  store/load byte enables
d_ack  out  1  one-cycle pulse when the data access completes
d_rdata  out  DATA_W  load word; valid while d_ack=1, held until next data ack
grant  out  2  01=fetch owns bus, 10=data owns bus, 00=idle
address  out  ADDR_W  bus address
write  out  1  bus write strobe
read  out  1  bus read strobe
waitrequest  in  1  bus stall
writedata  out  DATA_W  bus write data
byteenable  out  DATA_W/8  bus byte enables
readdata  in  DATA_W  bus read data; valid in the cycle read=1 and waitrequest=0

Behaviour:
- All outputs are registered. Reset values: read=0, write=0, address=0, writedata=0, byteenable=0, i_ack=0, d_ack=0, i_rdata=0, d_rdata=0, grant=00, state=IDLE.
- States: IDLE, BUS_I, BUS_D.
- IDLE: a requester is eligible when its req=1 and its own ack=0 in the current cycle.
  - Stale requests are thus ignored during the ack cycle.
  - Default arbitration is fixed priority: data over fetch.
- IDLE -> BUS_D:
  - Latch d_addr, d_wdata and d_be onto address, writedata and byteenable.
  - Assert write=d_we and read=!d_we; grant=10.
- IDLE -> BUS_I:
  - address=i_addr, byteenable=1111, writedata=0, read=1, write=0; grant=01.
- BUS_x with waitrequest=1: all bus outputs held stable, no ack. Stalls are unbounded.
- BUS_x with waitrequest=0 (the completing edge):
  - Deassert read/write; grant=00; go to IDLE.
  - Pulse x_ack=1 for exactly one cycle.
  - For reads, capture readdata into x_rdata.
  - For stores, d_rdata is unchanged.
- Latency with zero wait states: req sampled at edge 0 -> strobe high in cycle 1 -> ack high in cycle 2. One bus transaction per 2 cycles minimum.
- Request timing:
  - A request arriving while the other port owns the bus waits in IDLE arbitration.
  - A request arriving in the same cycle as the other port's ack is eligible immediately.
- Simultaneous i_req and d_req in IDLE: data is granted (fixed priority). Fetch is served next IDLE cycle if still pending.
- Requesters must not change fields while req=1 before ack. The arbiter uses latched copies, so later changes do not corrupt an in-flight access.
- Reset mid-transaction: at the reset edge, strobes drop and acks stay 0. The in-flight access is abandoned; no ack is ever issued for it.
- Addresses are passed unmodified; alignment checking is the requesters' responsibility.

Optional Feature:
ARB_ROUND_ROBIN_EN
- Defined: when both ports are eligible in IDLE, grant goes to the port not served last. A 1-bit last-served register resets to "fetch served", so the first contended grant goes to data.
- Undefined: fixed data-over-fetch priority as above; the last-served register is absent.

Test Plan:
- Reset, then i_req=1, i_addr=0xBFC00000, zero wait, readdata=0x8C020010 -> read=1 with address=0xBFC00000 in cycle 1; i_ack=1 with i_rdata=0x8C020010 in cycle 2; i_ack low in cycle 3.
- d_req=1, d_we=0, d_addr=0x00000010, d_be=1111; RAM holds 0xCAFE2105; waitrequest high for 3 cycles -> read and address held stable for 4 cycles; d_ack one pulse with d_rdata=0xCAFE2105.
- d_req=1, d_we=1, d_addr=0x00000020, d_wdata=0x12345678, d_be=0011 -> write=1, writedata=0x12345678, byteenable=0011 for one cycle; d_ack pulses; d_rdata unchanged; readback via fetch returns 0x00005678 in the low half.
- i_req and d_req asserted in the same cycle -> grant=10 first, then grant=01. With ARB_ROUND_ROBIN_EN, a repeated contended pair alternates 10, 01, 10, 01.
- Requester holds req during the ack cycle -> no duplicate transaction: read stays 0 in the cycle after ack.
- reset asserted while in BUS_D with waitrequest=1 -> read=0, d_ack=0, grant=00 next cycle; no later d_ack.
